// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic inter-stage pipeline register with a valid/ready handshake, flush and
//   an optional 2-entry skid buffer. Payload is split into data (content only)
//   and ctrl (side-effect bits). Every empty slot holds data=0 and ctrl=0, so a
//   bubble can never leak control bits downstream.
//
//   Parameters
//     DATA_WIDTH  payload data bits
//     CTRL_WIDTH  control bits, zero on bubble / flush / reset
//     SKID        1: 2-entry skid, registered in_ready_o
//                 0: single entry, combinational in_ready_o
//
//   Ports
//     clk_i        rising-edge clock
//     rst_i        synchronous active-high reset (wins over flush_i)
//     flush_i      discard all held entries and any entry offered this cycle
//     in_valid_i   upstream offers an entry
//     in_ready_o   stage accepts an entry this cycle
//     in_data_i    upstream data
//     in_ctrl_i    upstream control bits
//     out_valid_o  out_data_o/out_ctrl_o hold a live entry
//     out_ready_i  downstream consumes the head entry this cycle
//     out_data_o   head entry data, 0 when out_valid_o=0
//     out_ctrl_o   head entry control, 0 when out_valid_o=0
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 8,
    parameter int SKID       = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [CTRL_WIDTH-1:0] out_ctrl_o
);

    // Occupancy states of the skid variant.
    localparam logic [1:0] ST_EMPTY = 2'd0;  // nothing held
    localparam logic [1:0] ST_ONE   = 2'd1;  // main slot full
    localparam logic [1:0] ST_TWO   = 2'd2;  // main and skid slots full

    logic accept;   // entry enters the stage at this edge
    logic consume;  // head entry leaves the stage at this edge

    assign accept  = in_valid_i & in_ready_o;
    assign consume = out_valid_o & out_ready_i;

    generate
        if (SKID != 0) begin : g_skid
            logic [1:0]            state_q,     state_d;
            logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
            logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
            logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
            logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
            logic                  in_ready_q,  in_ready_d;
            logic                  out_valid_q, out_valid_d;

            always_comb begin
                state_d     = state_q;
                main_data_d = main_data_q;
                main_ctrl_d = main_ctrl_q;
                skid_data_d = skid_data_q;
                skid_ctrl_d = skid_ctrl_q;

                case (state_q)
                    ST_EMPTY: begin
                        if (accept) begin
                            main_data_d = in_data_i;
                            main_ctrl_d = in_ctrl_i;
                            state_d     = ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (accept && consume) begin
                            // Head leaves while a new entry arrives: stay at one.
                            main_data_d = in_data_i;
                            main_ctrl_d = in_ctrl_i;
                        end else if (accept) begin
                            // Downstream stalled: park the new entry in the skid slot.
                            skid_data_d = in_data_i;
                            skid_ctrl_d = in_ctrl_i;
                            state_d     = ST_TWO;
                        end else if (consume) begin
                            main_data_d = '0;
                            main_ctrl_d = '0;
                            state_d     = ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        // in_ready_o is low here, so only a consume can happen.
                        if (consume) begin
                            main_data_d = skid_data_q;
                            main_ctrl_d = skid_ctrl_q;
                            skid_data_d = '0;
                            skid_ctrl_d = '0;
                            state_d     = ST_ONE;
                        end
                    end
                    default: begin
                        main_data_d = '0;
                        main_ctrl_d = '0;
                        skid_data_d = '0;
                        skid_ctrl_d = '0;
                        state_d     = ST_EMPTY;
                    end
                endcase

                // Flush drops everything, including an entry offered this cycle.
                if (flush_i) begin
                    main_data_d = '0;
                    main_ctrl_d = '0;
                    skid_data_d = '0;
                    skid_ctrl_d = '0;
                    state_d     = ST_EMPTY;
                end

                // Both flags are computed from the next state and registered, so
                // in_ready_o has no combinational path from out_ready_i.
                in_ready_d  = (state_d != ST_TWO);
                out_valid_d = (state_d != ST_EMPTY);
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state_q     <= ST_EMPTY;
                    main_data_q <= '0;
                    main_ctrl_q <= '0;
                    skid_data_q <= '0;
                    skid_ctrl_q <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end else begin
                    state_q     <= state_d;
                    main_data_q <= main_data_d;
                    main_ctrl_q <= main_ctrl_d;
                    skid_data_q <= skid_data_d;
                    skid_ctrl_q <= skid_ctrl_d;
                    in_ready_q  <= in_ready_d;
                    out_valid_q <= out_valid_d;
                end
            end

            assign in_ready_o  = in_ready_q;
            assign out_valid_o = out_valid_q;
            assign out_data_o  = main_data_q;
            assign out_ctrl_o  = main_ctrl_q;
        end else begin : g_single
            logic                  valid_q, valid_d;
            logic [DATA_WIDTH-1:0] data_q,  data_d;
            logic [CTRL_WIDTH-1:0] ctrl_q,  ctrl_d;

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                ctrl_d  = ctrl_q;
                if (accept) begin
                    valid_d = 1'b1;
                    data_d  = in_data_i;
                    ctrl_d  = in_ctrl_i;
                end else if (consume) begin
                    valid_d = 1'b0;
                    data_d  = '0;
                    ctrl_d  = '0;
                end
                if (flush_i) begin
                    valid_d = 1'b0;
                    data_d  = '0;
                    ctrl_d  = '0;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    ctrl_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                    ctrl_q  <= ctrl_d;
                end
            end

            // Single slot: room exists if it is empty or being drained this cycle.
            assign in_ready_o  = out_ready_i | ~valid_q;
            assign out_valid_o = valid_q;
            assign out_data_o  = data_q;
            assign out_ctrl_o  = ctrl_q;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Drives a SKID=1 and a SKID=0 instance from the same inputs. Each instance is
//   tracked by a FIFO model (a queue bounded at 2 or 1 entries); directed tables
//   and hand sequences add fixed expected values for the listed corner cases.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;
    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          sk_ir, sk_ov, ns_ir, ns_ov;
    logic [DW-1:0] sk_od, ns_od;
    logic [CW-1:0] sk_oc, ns_oc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SKID(1)) u_sk (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(sk_ir), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
        .out_valid_o(sk_ov), .out_ready_i(out_ready), .out_data_o(sk_od), .out_ctrl_o(sk_oc)
    );

    pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SKID(0)) u_ns (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(ns_ir), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
        .out_valid_o(ns_ov), .out_ready_i(out_ready), .out_data_o(ns_od), .out_ctrl_o(ns_oc)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t q_sk[$];
    ent_t q_ns[$];

    typedef struct {
        logic          vld;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          rdy;
        logic          fl;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [CW-1:0] e_oc;
        logic          e_ir;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: check in_ready before the edge, advance the models at the edge,
    // check the outputs at the following falling edge. Inputs must be stable.
    task automatic cycle();
        logic ir_sk_e, ir_ns_e;
        logic acc_sk, acc_ns, cons_sk, cons_ns;
        #1;
        ir_sk_e = (q_sk.size() < 2);
        ir_ns_e = out_ready || (q_ns.size() == 0);
        chk("sk_in_ready_pre", sk_ir, ir_sk_e);
        chk("ns_in_ready_pre", ns_ir, ir_ns_e);
        @(posedge clk);
        cons_sk = out_ready && (q_sk.size() > 0);
        cons_ns = out_ready && (q_ns.size() > 0);
        acc_sk  = in_valid && ir_sk_e;
        acc_ns  = in_valid && ir_ns_e;
        if (rst || flush) begin
            q_sk.delete();
            q_ns.delete();
        end else begin
            if (cons_sk) void'(q_sk.pop_front());
            if (acc_sk)  q_sk.push_back({in_data, in_ctrl});
            if (cons_ns) void'(q_ns.pop_front());
            if (acc_ns)  q_ns.push_back({in_data, in_ctrl});
        end
        @(negedge clk);
        chk("sk_out_valid", sk_ov, q_sk.size() != 0);
        chk("sk_out_data",  sk_od, (q_sk.size() != 0) ? q_sk[0].d : '0);
        chk("sk_out_ctrl",  sk_oc, (q_sk.size() != 0) ? q_sk[0].c : '0);
        chk("ns_out_valid", ns_ov, q_ns.size() != 0);
        chk("ns_out_data",  ns_od, (q_ns.size() != 0) ? q_ns[0].d : '0);
        chk("ns_out_ctrl",  ns_oc, (q_ns.size() != 0) ? q_ns[0].c : '0);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
        flush     = f;
    endtask

    initial begin
        // Directed vectors for the SKID=1 instance, starting from empty.
        //            vld   data   ctrl  rdy   fl    ov    od     oc     ir
        tbl[0]  = '{1'b1, 32'h10, 8'h03, 1'b1, 1'b0, 1'b1, 32'h10, 8'h03, 1'b1};
        tbl[1]  = '{1'b1, 32'h11, 8'h03, 1'b1, 1'b0, 1'b1, 32'h11, 8'h03, 1'b1};
        tbl[2]  = '{1'b1, 32'h12, 8'h03, 1'b1, 1'b0, 1'b1, 32'h12, 8'h03, 1'b1};
        tbl[3]  = '{1'b0, 32'h00, 8'h00, 1'b1, 1'b0, 1'b0, 32'h00, 8'h00, 1'b1};
        tbl[4]  = '{1'b1, 32'hA1, 8'h03, 1'b0, 1'b0, 1'b1, 32'hA1, 8'h03, 1'b1};
        tbl[5]  = '{1'b1, 32'hA2, 8'h03, 1'b0, 1'b0, 1'b1, 32'hA1, 8'h03, 1'b0};
        tbl[6]  = '{1'b1, 32'hA3, 8'h03, 1'b0, 1'b0, 1'b1, 32'hA1, 8'h03, 1'b0};
        tbl[7]  = '{1'b1, 32'hA3, 8'h03, 1'b1, 1'b0, 1'b1, 32'hA2, 8'h03, 1'b1};
        tbl[8]  = '{1'b1, 32'hA3, 8'h03, 1'b1, 1'b0, 1'b1, 32'hA3, 8'h03, 1'b1};
        tbl[9]  = '{1'b0, 32'h00, 8'h00, 1'b1, 1'b0, 1'b0, 32'h00, 8'h00, 1'b1};
        tbl[10] = '{1'b1, 32'hC0, 8'hFF, 1'b0, 1'b0, 1'b1, 32'hC0, 8'hFF, 1'b1};
        tbl[11] = '{1'b1, 32'hC1, 8'hFF, 1'b0, 1'b0, 1'b1, 32'hC0, 8'hFF, 1'b0};
        tbl[12] = '{1'b1, 32'hB0, 8'hFF, 1'b0, 1'b1, 1'b0, 32'h00, 8'h00, 1'b1};
        tbl[13] = '{1'b0, 32'h00, 8'h00, 1'b1, 1'b0, 1'b0, 32'h00, 8'h00, 1'b1};

        // Reset: two cycles high, then check the idle state.
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_sk_out_valid", sk_ov, 1'b0);
        chk("rst_sk_out_data",  sk_od, 32'h0);
        chk("rst_sk_out_ctrl",  sk_oc, 8'h0);
        chk("rst_sk_in_ready",  sk_ir, 1'b1);
        chk("rst_ns_out_valid", ns_ov, 1'b0);
        chk("rst_ns_in_ready",  ns_ir, 1'b1);

        // Streaming, skid fill/drain, flush with an offered entry.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].vld, tbl[i].d, tbl[i].c, tbl[i].rdy, tbl[i].fl);
            cycle();
            chk($sformatf("tbl%0d_out_valid", i), sk_ov, tbl[i].e_ov);
            chk($sformatf("tbl%0d_out_data", i),  sk_od, tbl[i].e_od);
            chk($sformatf("tbl%0d_out_ctrl", i),  sk_oc, tbl[i].e_oc);
            chk($sformatf("tbl%0d_in_ready", i),  sk_ir, tbl[i].e_ir);
        end

        // rst and flush together with two entries held.
        drive(1'b1, 32'hD0, 8'h5A, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'hD1, 8'h5A, 1'b0, 1'b0); cycle();
        rst = 1'b1;
        drive(1'b1, 32'hD2, 8'h5A, 1'b0, 1'b1); cycle();
        rst = 1'b0;
        chk("rstfl_sk_out_valid", sk_ov, 1'b0);
        chk("rstfl_sk_out_data",  sk_od, 32'h0);
        chk("rstfl_sk_out_ctrl",  sk_oc, 8'h0);
        chk("rstfl_sk_in_ready",  sk_ir, 1'b1);
        chk("rstfl_ns_out_valid", ns_ov, 1'b0);

        // SKID=0: in_ready follows out_ready combinationally while full.
        drive(1'b1, 32'hE0, 8'h11, 1'b0, 1'b0); cycle();
        chk("ns_hold_data", ns_od, 32'hE0);
        drive(1'b1, 32'hE1, 8'h22, 1'b0, 1'b0);
        #1;
        chk("ns_full_in_ready_low", ns_ir, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("ns_full_in_ready_high", ns_ir, 1'b1);
        cycle();
        chk("ns_replace_data", ns_od, 32'hE1);
        chk("ns_replace_ctrl", ns_oc, 8'h22);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (3) cycle();

        // Random traffic against the FIFO models.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(199) == 0);
            drive($urandom_range(1), $urandom, $urandom_range(255),
                  ($urandom_range(9) < 7), ($urandom_range(39) == 0));
            cycle();
        end

        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
